serial_slice_adder: RTL and testbench
=====================================

Name: serial_slice_adder

Overview:
- Parametrised multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, SLICE bits per clock, by rippling a registered carry between slices.
- Provides a START/BUSY/DONE handshake, sum, carry-out and signed overflow.
- Used as the area-lean arithmetic unit for wide datapaths where a single-cycle ripple is too slow or too large.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of SLICE.
- SLICE, 4: bits added per clock. Must be 1..WIDTH.
- NSLICE, WIDTH/SLICE: derived local parameter, not overridable. Number of compute cycles.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- SA_START  input  1  request a new operation; sampled only in IDLE or DONE.
- SA_A  input  WIDTH  operand A; captured when START is accepted.
- SA_B  input  WIDTH  operand B; captured when START is accepted.
- SA_C_0  input  1  carry-in; captured when START is accepted.
- SA_BUSY  output  1  operation in progress.
- SA_DONE  output  1  one-cycle pulse; result valid.
- SA_F  output  WIDTH  sum; holds until the next accepted START.
- SA_C_1  output  1  carry-out of the MSB.
- SA_OV  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: any cycle with RST=1 forces state IDLE and clears SA_BUSY, SA_DONE, SA_F, SA_C_1, SA_OV, the slice counter and the internal carry register to 0. RST has priority over SA_START and over an operation in progress.
- States:
  - IDLE: waits for SA_START.
  - RUN: computes one slice per cycle.
  - DONE: one cycle, then IDLE.
- Accept: SA_START=1 at edge t in IDLE or DONE.
  - Latch A, B and C_0 into operand registers.
  - Counter=0, carry register=C_0.
  - Clear SA_F, SA_C_1, SA_OV to 0. Clear SA_DONE.
  - Enter RUN with SA_BUSY=1.
- RUN, edge t+k (k=1..NSLICE):
  - Slice k-1 (bits [k*SLICE-1 : (k-1)*SLICE]) = A_slice + B_slice + carry.
  - Write the result into the matching SA_F bits.
  - Carry register takes the slice carry-out.
  - Counter increments.
- Completion, edge t+NSLICE (last slice):
  - SA_C_1 = final carry.
  - SA_OV = carry into bit WIDTH-1 XOR final carry.
  - SA_BUSY=0, SA_DONE=1, state DONE.
- Latency: SA_BUSY is high for exactly NSLICE cycles. SA_DONE is high for exactly one cycle, immediately after.
- DONE state:
  - SA_START=0: go to IDLE, SA_DONE=0.
  - SA_START=1: accepted exactly as in IDLE (back-to-back; no idle bubble).
- SA_START while in RUN is ignored. The operation is not restarted.
- Changes on SA_A, SA_B, SA_C_0 during RUN have no effect; only the latched copies are used.
- Intermediate SA_F bits are visible during RUN. Consumers use SA_F only with or after SA_DONE.
- SLICE=WIDTH degenerates to NSLICE=1: one RUN cycle, then DONE.
- Arithmetic is modulo 2^WIDTH; {SA_C_1, SA_F} is the exact WIDTH+1-bit sum.

Optional Feature:
- Macro: SA_SUB_EN.
- Defined:
  - Adds port SA_SUB (input, 1), captured with the operands on START acceptance.
  - SA_SUB=1 replaces the latched B with ~B, so result = A + ~B + C_0. Plain subtraction A-B uses C_0=1.
  - SA_C_1=1 means no borrow. SA_OV is the signed subtraction overflow.
  - SA_SUB=0 behaves as pure add.
- Undefined: no SA_SUB port; pure addition only; no extra logic.

Test Plan (WIDTH=16, SLICE=4, NSLICE=4):
- Reset: hold RST=1 for 2 cycles -> all outputs 0, state IDLE; SA_START during RST ignored.
- Basic add: A=0x1234, B=0x1111, C0=0, START pulse at edge t -> BUSY high edges t..t+3; DONE at edge t+4; F=0x2345, C1=0, OV=0.
- Full ripple: A=0xFFFF, B=0x0001, C0=0 -> F=0x0000, C1=1, OV=0. Then A=0x7FFF, B=0x0000, C0=1 -> F=0x8000, C1=0, OV=1.
- Handshake:
  - START re-asserted mid-RUN, with operands changed, -> ignored; first result intact.
  - START held high during the DONE cycle with A=0x0001, B=0x0002 -> accepted back-to-back; next DONE 4 cycles later with F=0x0003.
- Reset mid-operation: RST=1 at the second RUN cycle -> next cycle BUSY=0, DONE=0, F=0; no DONE pulse follows. A new START afterwards completes normally.
- SA_SUB_EN build: A=0x0005, B=0x0007, SUB=1, C0=1 -> F=0xFFFE, C1=0 (borrow), OV=0. A=0x8000, B=0x0001, SUB=1, C0=1 -> F=0x7FFF, C1=1, OV=1.

Source files
------------

// File: rtl/serial_slice_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands SLICE bits per clock, rippling a registered carry.
// Optional build macro SA_SUB_EN adds SA_SUB (result = A + ~B + C_0).

module serial_slice_adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);
  logic [SLICE:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_c};
  assign o_sum  = w_full[SLICE-1:0];
  assign o_cout = w_full[SLICE];
  // Carry into the top bit recovered from that bit's sum and operands.
  assign o_cmsb = w_full[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];
endmodule

module serial_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SA_START,
  input  logic [WIDTH-1:0] SA_A,
  input  logic [WIDTH-1:0] SA_B,
  input  logic             SA_C_0,
`ifdef SA_SUB_EN
  input  logic             SA_SUB,
`endif
  output logic             SA_BUSY,
  output logic             SA_DONE,
  output logic [WIDTH-1:0] SA_F,
  output logic             SA_C_1,
  output logic             SA_OV
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_f, w_b_in;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_c1, r_ov;
  logic             w_accept, w_last;
  logic [SLICE-1:0] w_sum;
  logic             w_cout, w_cmsb;

`ifdef SA_SUB_EN
  assign w_b_in = SA_B ^ {WIDTH{SA_SUB}};
`else
  assign w_b_in = SA_B;
`endif

  assign w_last = (r_cnt == CW'(NSLICE - 1));

  // Operand registers shift down each cycle, so the active slice is always the low bits.
  serial_slice_adder_slice #(.SLICE(SLICE)) u_slice (
    .i_a    (r_a[SLICE-1:0]),
    .i_b    (r_b[SLICE-1:0]),
    .i_c    (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (SA_START) begin
        w_accept    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN:  if (w_last) w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
        if (SA_START) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c1    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= SA_A;
      r_b     <= w_b_in;
      r_f     <= '0;
      r_cnt   <= '0;
      r_carry <= SA_C_0;
      r_c1    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      for (int j = 0; j < NSLICE; j++)
        if (r_cnt == CW'(j)) r_f[j*SLICE +: SLICE] <= w_sum;
      if (w_last) begin
        r_c1 <= w_cout;
        r_ov <= w_cmsb ^ w_cout;
      end
    end
  end

  assign SA_BUSY = (r_state == RUN);
  assign SA_DONE = (r_state == DONE);
  assign SA_F    = r_f;
  assign SA_C_1  = r_c1;
  assign SA_OV   = r_ov;
endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: directed table, handshake/reset sequences, random vs arithmetic model.
module tb_serial_slice_adder;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SA_START;
  logic [W-1:0] SA_A, SA_B;
  logic         SA_C_0;
  logic         sub;
  logic         SA_BUSY, SA_DONE, SA_C_1, SA_OV;
  logic [W-1:0] SA_F;

  int n_chk = 0;
  int n_err = 0;

  serial_slice_adder #(.WIDTH(W), .SLICE(S)) dut (
    .CLK(CLK), .RST(RST), .SA_START(SA_START), .SA_A(SA_A), .SA_B(SA_B), .SA_C_0(SA_C_0),
`ifdef SA_SUB_EN
    .SA_SUB(sub),
`endif
    .SA_BUSY(SA_BUSY), .SA_DONE(SA_DONE), .SA_F(SA_F), .SA_C_1(SA_C_1), .SA_OV(SA_OV)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a, b;
    logic         c0;
    logic [W-1:0] f;
    logic         c1, ov;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0, input logic sb,
                       output logic [W-1:0] f, output logic c1, output logic ov);
    longint ua, ub, sa, sbv, us, ss;
    logic [W-1:0] be;
    be  = sb ? ~b : b;
    ua  = longint'(a);
    ub  = longint'(be);
    us  = ua + ub + longint'(c0);
    sa  = (ua >= 32768) ? ua - 65536 : ua;
    sbv = (ub >= 32768) ? ub - 65536 : ub;
    ss  = sa + sbv + longint'(c0);
    f   = W'(us % 65536);
    c1  = (us >= 65536);
    ov  = (ss > 32767) || (ss < -32768);
  endtask

  // Issues START, checks busy length and final result; returns in the DONE cycle.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c0, input logic sb,
                       input logic [W-1:0] ef, input logic ec1, input logic eov);
    int nb;
    SA_A = a; SA_B = b; SA_C_0 = c0; sub = sb; SA_START = 1'b1;
    tick();
    SA_START = 1'b0;
    chk({nm, " busy_after_accept"}, SA_BUSY, 1);
    chk({nm, " f_cleared"}, (NS > 1) ? SA_F & ~W'(16'h000F) : 0, 0);
    nb = 0;
    while (SA_BUSY && nb < 100) begin
      nb++;
      tick();
    end
    chk({nm, " busy_cycles"}, nb, NS);
    chk({nm, " done"}, SA_DONE, 1);
    chk({nm, " f"}, SA_F, ef);
    chk({nm, " c1"}, SA_C_1, ec1);
    chk({nm, " ov"}, SA_OV, eov);
  endtask

  initial begin
    vec_t tbl[6];
    logic [W-1:0] mf;
    logic mc1, mov, seen;

    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    RST = 1'b1; SA_START = 1'b1; SA_A = 16'h1234; SA_B = 16'h4321; SA_C_0 = 1'b1; sub = 1'b0;
    tick(); tick();
    chk("rst busy", SA_BUSY, 0);
    chk("rst done", SA_DONE, 0);
    chk("rst f", SA_F, 0);
    chk("rst c1", SA_C_1, 0);
    chk("rst ov", SA_OV, 0);
    RST = 1'b0; SA_START = 1'b0;
    tick();
    chk("rst start_ignored", SA_BUSY, 0);

    // Directed table, one idle cycle between operations.
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c0, 1'b0, tbl[i].f, tbl[i].c1, tbl[i].ov);
      tick();
      chk($sformatf("vec%0d done_pulse", i), SA_DONE, 0);
    end

    // START mid-RUN with changed operands is ignored.
    SA_A = 16'h1234; SA_B = 16'h1111; SA_C_0 = 1'b0; SA_START = 1'b1;
    tick();
    SA_START = 1'b0;
    tick();
    SA_START = 1'b1; SA_A = 16'hFFFF; SA_B = 16'hFFFF; SA_C_0 = 1'b1;
    tick(); tick();
    SA_START = 1'b0;
    chk("midrun busy", SA_BUSY, 1);
    tick();
    chk("midrun done", SA_DONE, 1);
    chk("midrun f", SA_F, 16'h2345);
    chk("midrun c1", SA_C_1, 0);
    tick();
    chk("midrun no_restart", SA_BUSY, 0);

    // Back-to-back: START during DONE is accepted with no bubble.
    do_op("b2b_first", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_op("b2b_second", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    tick();

    // Reset in the second RUN cycle kills the operation.
    SA_A = 16'hFFFF; SA_B = 16'h0001; SA_C_0 = 1'b0; SA_START = 1'b1;
    tick();
    SA_START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst busy", SA_BUSY, 0);
    chk("midrst done", SA_DONE, 0);
    chk("midrst f", SA_F, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (SA_DONE || SA_BUSY) seen = 1'b1;
    end
    chk("midrst no_done", seen, 0);
    do_op("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    tick();

`ifdef SA_SUB_EN
    do_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tick();
    do_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tick();
`endif

    // Random operations, occasionally back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SA_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rc, rs, mf, mc1, mov);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, mf, mc1, mov);
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick(); tick();
    chk("end idle", SA_BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
